// File: rtl/int_sequencer.sv
// Interrupt entry/return sequencer: grants controller requests, redirects the PC and keeps a
// saved-context stack. Define INT_NEST_EN to allow nested entry up to DEPTH levels.
module int_sequencer #(
    parameter int          PC_W       = 16,
    parameter int unsigned VEC_BASE   = 16'h0010,
    parameter int unsigned VEC_STRIDE = 4,
    parameter int          DEPTH      = 4
) (
    input  logic            clk,
    input  logic            in_RST,
    input  logic            in_break,
    input  logic [1:0]      in_code,
    input  logic            in_instr_done,
    input  logic            in_eret,
    input  logic [PC_W-1:0] in_pc,
    input  logic            in_inm_we,
    input  logic [3:0]      in_inm_wdata,
    input  logic            in_ie_set,
    input  logic            in_ie_clr,
    output logic [3:0]      out_IG,
    output logic [3:0]      out_INM,
    output logic            out_IE,
    output logic            out_pc_load,
    output logic [PC_W-1:0] out_pc_value,
    output logic            out_stall,
    output logic [2:0]      out_depth,
    output logic            out_err
);

`ifdef INT_NEST_EN
    localparam int   EFF_DEPTH = DEPTH;
    localparam logic NEST      = 1'b1;
`else
    localparam int   EFF_DEPTH = (DEPTH > 1) ? 1 : DEPTH;
    localparam logic NEST      = 1'b0;
`endif
    localparam int          AW        = (EFF_DEPTH > 1) ? $clog2(EFF_DEPTH) : 1;
    localparam int          SLOTS     = 1 << AW;
    localparam logic [2:0]  DEPTH_MAX = 3'(EFF_DEPTH);

    typedef enum logic [1:0] {IDLE, ACK, JUMP, RET} state_t;

    state_t            state, state_nxt;
    logic [1:0]        code, code_nxt;
    logic [2:0]        depth, depth_nxt;
    logic [3:0]        inm_nxt, ig_nxt, grant_mask;
    logic              ie_nxt, pc_load_nxt, err_nxt, stall_nxt, push;
    logic [PC_W-1:0]   pc_value_nxt;
    logic [AW-1:0]     push_idx, pop_idx;

    logic [PC_W-1:0]   stk_pc  [SLOTS];
    logic [3:0]        stk_inm [SLOTS];
    logic              stk_ie  [SLOTS];

    assign grant_mask = 4'((5'd2 << code) - 5'd1);
    assign push_idx   = depth[AW-1:0];
    assign pop_idx    = AW'(depth - 3'd1);
    assign out_depth  = depth;

    always_comb begin
        state_nxt    = state;
        code_nxt     = code;
        depth_nxt    = depth;
        inm_nxt      = out_INM;
        ie_nxt       = out_IE;
        ig_nxt       = '0;
        pc_load_nxt  = 1'b0;
        pc_value_nxt = out_pc_value;
        err_nxt      = 1'b0;
        push         = 1'b0;
        case (state)
            IDLE: begin
                err_nxt = in_eret && in_instr_done && (depth == '0);
                if (in_eret && in_instr_done && (depth != '0)) begin
                    state_nxt    = RET;
                    pc_load_nxt  = 1'b1;
                    pc_value_nxt = stk_pc[pop_idx];
                    inm_nxt      = stk_inm[pop_idx];
                    ie_nxt       = stk_ie[pop_idx];
                    depth_nxt    = depth - 3'd1;
                end else if (in_break && in_instr_done && (depth < DEPTH_MAX)) begin
                    // context is pushed on entry; INM/IE cannot change before ACK
                    state_nxt = ACK;
                    code_nxt  = in_code;
                    ig_nxt    = 4'b0001 << in_code;
                    push      = 1'b1;
                end else begin
                    if (in_inm_we) inm_nxt = in_inm_wdata;
                    if (in_ie_clr)      ie_nxt = 1'b0;
                    else if (in_ie_set) ie_nxt = 1'b1;
                end
            end
            ACK: begin
                state_nxt    = JUMP;
                inm_nxt      = out_INM | grant_mask;
                ie_nxt       = 1'b0;
                depth_nxt    = depth + 3'd1;
                pc_load_nxt  = 1'b1;
                pc_value_nxt = PC_W'(VEC_BASE + 32'(code) * VEC_STRIDE);
            end
            JUMP: begin
                state_nxt = IDLE;
                ie_nxt    = NEST;
            end
            RET: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        stall_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge in_RST) begin
        if (in_RST) begin
            state        <= IDLE;
            code         <= '0;
            depth        <= '0;
            out_IG       <= '0;
            out_INM      <= '0;
            out_IE       <= 1'b0;
            out_pc_load  <= 1'b0;
            out_pc_value <= '0;
            out_stall    <= 1'b0;
            out_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            code         <= code_nxt;
            depth        <= depth_nxt;
            out_IG       <= ig_nxt;
            out_INM      <= inm_nxt;
            out_IE       <= ie_nxt;
            out_pc_load  <= pc_load_nxt;
            out_pc_value <= pc_value_nxt;
            out_stall    <= stall_nxt;
            out_err      <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            stk_pc[push_idx]  <= in_pc;
            stk_inm[push_idx] <= out_INM;
            stk_ie[push_idx]  <= out_IE;
        end
    end

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: directed scenarios plus a random entry/return walk
// against a queue-based context model.
module tb_int_sequencer;
`ifdef INT_NEST_EN
    localparam int   EFF  = 4;
    localparam logic NEST = 1'b1;
`else
    localparam int   EFF  = 1;
    localparam logic NEST = 1'b0;
`endif

    logic        clk, in_RST, in_break, in_instr_done, in_eret;
    logic [1:0]  in_code;
    logic [15:0] in_pc;
    logic        in_inm_we, in_ie_set, in_ie_clr;
    logic [3:0]  in_inm_wdata;
    logic [3:0]  out_IG, out_INM;
    logic        out_IE, out_pc_load, out_stall, out_err;
    logic [15:0] out_pc_value;
    logic [2:0]  out_depth;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] pc;
        logic [3:0]  inm;
        logic        ie;
    } ctx_t;
    ctx_t       ctx_q[$];
    logic [3:0] m_inm;
    logic       m_ie;

    int_sequencer #(.PC_W(16), .VEC_BASE(16'h0010), .VEC_STRIDE(4), .DEPTH(4)) dut (
        .clk(clk), .in_RST(in_RST), .in_break(in_break), .in_code(in_code),
        .in_instr_done(in_instr_done), .in_eret(in_eret), .in_pc(in_pc),
        .in_inm_we(in_inm_we), .in_inm_wdata(in_inm_wdata), .in_ie_set(in_ie_set),
        .in_ie_clr(in_ie_clr), .out_IG(out_IG), .out_INM(out_INM), .out_IE(out_IE),
        .out_pc_load(out_pc_load), .out_pc_value(out_pc_value), .out_stall(out_stall),
        .out_depth(out_depth), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] vec_of(input int c);
        return 16'(16 + c * 4);
    endfunction

    function automatic logic [3:0] mask_of(input int c);
        return 4'((1 << (c + 1)) - 1);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        in_break = 0; in_code = 0; in_instr_done = 0; in_eret = 0;
        in_inm_we = 0; in_inm_wdata = 0; in_ie_set = 0; in_ie_clr = 0;
    endtask

    task automatic noise_inputs;
        in_break = 1'($urandom); in_code = 2'($urandom); in_instr_done = 1'($urandom);
        in_eret = 1'($urandom); in_pc = 16'($urandom); in_inm_we = 1'b1;
        in_inm_wdata = 4'($urandom); in_ie_set = 1'($urandom); in_ie_clr = 1'($urandom);
    endtask

    task automatic do_entry(input logic [1:0] c, input logic [15:0] pc);
        logic [5:0]  g6, e6;
        logic [28:0] g29, e29;
        logic [24:0] g25, e25;
        clear_inputs();
        in_break = 1; in_code = c; in_instr_done = 1; in_pc = pc;
        in_inm_we = 1; in_inm_wdata = 4'($urandom); in_ie_set = 1;
        tick();
        ctx_q.push_back('{pc, m_inm, m_ie});
        g6 = {out_IG, out_stall, out_pc_load};
        e6 = {4'(1 << c), 1'b1, 1'b0};
        checks++;
        if (g6 !== e6) begin
            errors++;
            $display("FAIL ack_grant: got %b expected %b", g6, e6);
        end
        noise_inputs();
        tick();
        m_inm = m_inm | mask_of(c);
        m_ie  = 1'b0;
        g29 = {out_pc_load, out_pc_value, out_INM, out_IE, out_depth, out_IG};
        e29 = {1'b1, vec_of(c), m_inm, 1'b0, 3'(ctx_q.size()), 4'b0};
        checks++;
        if (g29 !== e29 || out_stall !== 1'b1) begin
            errors++;
            $display("FAIL jump_redirect: got %h stall %b expected %h stall 1", g29, out_stall, e29);
        end
        noise_inputs();
        tick();
        clear_inputs();
        m_ie = NEST;
        g25 = {out_pc_load, out_IE, out_INM, out_stall, out_depth, out_IG, out_err, 10'b0};
        e25 = {1'b0, m_ie, m_inm, 1'b0, 3'(ctx_q.size()), 4'b0, 1'b0, 10'b0};
        checks++;
        if (g25 !== e25) begin
            errors++;
            $display("FAIL entry_done: got %h expected %h", g25, e25);
        end
    endtask

    task automatic do_eret(input logic with_break);
        ctx_t        ctx;
        logic [29:0] g30, e30;
        logic [7:0]  g8, e8;
        clear_inputs();
        in_eret = 1; in_instr_done = 1; in_break = with_break; in_code = 2'($urandom);
        tick();
        ctx   = ctx_q.pop_back();
        m_inm = ctx.inm;
        m_ie  = ctx.ie;
        g30 = {out_pc_load, out_pc_value, out_INM, out_IE, out_depth, out_IG, out_stall};
        e30 = {1'b1, ctx.pc, m_inm, m_ie, 3'(ctx_q.size()), 4'b0, 1'b1};
        checks++;
        if (g30 !== e30) begin
            errors++;
            $display("FAIL ret_restore: got %h expected %h", g30, e30);
        end
        clear_inputs();
        tick();
        g8 = {out_pc_load, out_stall, out_INM, out_IE, out_IG[0]};
        e8 = {1'b0, 1'b0, m_inm, m_ie, 1'b0};
        checks++;
        if (g8 !== e8) begin
            errors++;
            $display("FAIL ret_done: got %b expected %b", g8, e8);
        end
    endtask

    task automatic sw_write(input logic [3:0] inm, input logic set, input logic clr);
        clear_inputs();
        in_inm_we = 1; in_inm_wdata = inm; in_ie_set = set; in_ie_clr = clr;
        tick();
        clear_inputs();
        m_inm = inm;
        if (clr)      m_ie = 1'b0;
        else if (set) m_ie = 1'b1;
        checks++;
        if ({out_INM, out_IE, out_stall} !== {m_inm, m_ie, 1'b0}) begin
            errors++;
            $display("FAIL sw_write: got INM %b IE %b stall %b expected INM %b IE %b stall 0",
                     out_INM, out_IE, out_stall, m_inm, m_ie);
        end
    endtask

    task automatic test_reset;
        logic [30:0] all_out;
        in_RST = 1; clear_inputs(); in_pc = 0;
        #12;
        all_out = {out_IG, out_INM, out_IE, out_pc_load, out_pc_value, out_stall, out_depth, out_err};
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        in_RST = 0;
        ctx_q.delete(); m_inm = 0; m_ie = 0;
        tick();
    endtask

    task automatic test_entry_return;
        sw_write(4'b0000, 1'b1, 1'b0);
        do_entry(2'd2, 16'h0100);
        checks++;
        if ({out_INM, out_depth} !== {4'b0111, 3'd1}) begin
            errors++;
            $display("FAIL entry_code2: got INM %b depth %0d expected 0111 depth 1", out_INM, out_depth);
        end
        do_eret(1'b0);
        checks++;
        if ({out_INM, out_IE, out_depth} !== {4'b0000, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL return_code2: got INM %b IE %b depth %0d expected 0000 1 0",
                     out_INM, out_IE, out_depth);
        end
    endtask

    task automatic test_full_stack;
        sw_write(4'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < EFF; i++) do_entry(2'($urandom), 16'($urandom));
        in_break = 1; in_instr_done = 1; in_code = 2'($urandom);
        tick();
        clear_inputs();
        checks++;
        if ({out_IG, out_stall, out_pc_load, out_depth} !== {4'b0, 1'b0, 1'b0, 3'(EFF)}) begin
            errors++;
            $display("FAIL full_ignore: got IG %b stall %b load %b depth %0d expected 0 0 0 %0d",
                     out_IG, out_stall, out_pc_load, out_depth, EFF);
        end
        tick();
        while (ctx_q.size() > 0) do_eret(1'b0);
    endtask

    task automatic test_eret_priority;
        sw_write(4'b0000, 1'b1, 1'b0);
        do_entry(2'($urandom), 16'($urandom));
        do_eret(1'b1);
    endtask

    task automatic test_err;
        sw_write(4'($urandom), 1'($urandom), 1'b0);
        in_eret = 1; in_instr_done = 1;
        tick();
        clear_inputs();
        checks++;
        if ({out_err, out_pc_load, out_INM, out_IE, out_depth, out_stall} !==
            {1'b1, 1'b0, m_inm, m_ie, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL eret_empty: got err %b load %b INM %b IE %b depth %0d expected 1 0 %b %b 0",
                     out_err, out_pc_load, out_INM, out_IE, out_depth, m_inm, m_ie);
        end
        in_break = 1; in_code = 2'($urandom);
        tick();
        clear_inputs();
        checks++;
        if ({out_err, out_IG, out_stall} !== 6'b0) begin
            errors++;
            $display("FAIL no_instr_done: got err %b IG %b stall %b expected all 0",
                     out_err, out_IG, out_stall);
        end
    endtask

    task automatic test_reset_mid;
        logic [30:0] all_out;
        clear_inputs();
        in_break = 1; in_instr_done = 1; in_code = 2'd1; in_pc = 16'h0200;
        tick();
        clear_inputs();
        tick();
        checks++;
        if (out_pc_load !== 1'b1) begin
            errors++;
            $display("FAIL mid_jump_load: got %b expected 1", out_pc_load);
        end
        #2 in_RST = 1;
        #1;
        all_out = {out_IG, out_INM, out_IE, out_pc_load, out_pc_value, out_stall, out_depth, out_err};
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL mid_reset: got %h expected 0", all_out);
        end
        @(negedge clk) in_RST = 0;
        ctx_q.delete(); m_inm = 0; m_ie = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({out_pc_load, out_IG, out_stall, out_depth} !== 9'b0) begin
                errors++;
                $display("FAIL post_reset_quiet: got load %b IG %b stall %b depth %0d expected 0",
                         out_pc_load, out_IG, out_stall, out_depth);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    if (ctx_q.size() < EFF) do_entry(2'($urandom), 16'($urandom));
                    else begin
                        in_break = 1; in_instr_done = 1; in_code = 2'($urandom);
                        tick();
                        clear_inputs();
                        checks++;
                        if ({out_IG, out_stall} !== 5'b0) begin
                            errors++;
                            $display("FAIL rand_full_ignore: got IG %b stall %b expected 0",
                                     out_IG, out_stall);
                        end
                    end
                end
                2: if (ctx_q.size() > 0) do_eret(1'($urandom));
                default: sw_write(4'($urandom), 1'($urandom), 1'($urandom));
            endcase
        end
        while (ctx_q.size() > 0) do_eret(1'b0);
    endtask

    initial begin
        in_pc = 0;
        test_reset();
        test_entry_return();
        test_full_stack();
        test_eret_priority();
        test_err();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
